// File: rtl/mac_job_fsm.sv
// Job sequencer for the MAC accelerator: runs nb_iter iterations of stream/engine starts,
// waits for all stream-done pulses per iteration, and pulses done_o at job end.
module mac_job_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [CNT_W-1:0] nb_iter_i,
  input  logic             acc_mode_i,
  input  logic             a_done_i,
  input  logic             b_done_i,
  input  logic             c_done_i,
  input  logic             d_done_i,
  output logic             stream_start_o,
  output logic             engine_start_o,
  output logic             acc_clear_o,
  output logic [CNT_W-1:0] len_o,
  output logic [CNT_W-1:0] iter_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStarting,
    StCompute,
    StWaitSink,
    StUpdate,
    StTerminate
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] nb_iter_q, nb_iter_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             acc_mode_q, acc_mode_d;
  // Sticky done flags, bit order {d, c, b, a}
  logic [3:0]       flags_q, flags_d;

  logic [3:0]       done_vec;
  logic             src_all_done;
  logic             sink_done;

  assign done_vec     = {d_done_i, c_done_i, b_done_i, a_done_i};
  assign src_all_done = &(flags_q[2:0] | done_vec[2:0]);
  assign sink_done    = flags_q[3] | d_done_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      nb_iter_q  <= '0;
      iter_q     <= '0;
      acc_mode_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      nb_iter_q  <= nb_iter_d;
      iter_q     <= iter_d;
      acc_mode_q <= acc_mode_d;
      flags_q    <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    nb_iter_d  = nb_iter_q;
    iter_d     = iter_q;
    acc_mode_d = acc_mode_q;
    flags_d    = flags_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d      = len_i;
          nb_iter_d  = nb_iter_i;
          acc_mode_d = acc_mode_i;
          iter_d     = '0;
          state_d    = ((len_i == '0) || (nb_iter_i == '0)) ? StTerminate : StStarting;
        end
      end
      StStarting: begin
        flags_d = '0;
        state_d = StCompute;
      end
      StCompute: begin
        flags_d = flags_q | done_vec;
        if (src_all_done) state_d = StWaitSink;
      end
      StWaitSink: begin
        flags_d = flags_q | done_vec;
        if (sink_done) state_d = StUpdate;
      end
      StUpdate: begin
        // Compare against nb_iter-1 so the counter never wraps at the max iteration count
        if (iter_q == nb_iter_q - CNT_W'(1)) begin
          state_d = StTerminate;
        end else begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = StStarting;
        end
      end
      StTerminate: state_d = StIdle;
      default:     state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d    = StIdle;
      len_d      = '0;
      nb_iter_d  = '0;
      iter_d     = '0;
      acc_mode_d = 1'b0;
      flags_d    = '0;
    end
  end

  always_comb begin
    stream_start_o = (state_q == StStarting);
    engine_start_o = (state_q == StStarting);
    acc_clear_o    = (state_q == StStarting) && (!acc_mode_q || (iter_q == '0));
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StTerminate);
    len_o          = len_q;
    iter_o         = iter_q;
  end

endmodule
